// File: rtl/soml_pkg.sv
// Shared types and defaults for the SOML decoder metric path.
// Used by the per-candidate accumulator and the minimum selector.
package soml_pkg;

  localparam int DW_DEF    = 16;
  localparam int NCAND_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/soml_min_cmp.sv
// Combinational running-minimum step: keeps the earlier index on ties.
// Also usable as a node of a tree-based parallel min search.
module soml_min_cmp #(
  parameter int DW = 16,
  parameter int IW = 3
) (
  input  logic          first,
  input  logic [DW-1:0] metric_in,
  input  logic [DW-1:0] best_metric,
  input  logic [IW-1:0] cnt,
  input  logic [IW-1:0] best_idx,
  output logic [DW-1:0] nxt_metric,
  output logic [IW-1:0] nxt_idx
);

  logic take;

  assign take = first || (metric_in < best_metric);

  always_comb begin
    nxt_metric = best_metric;
    nxt_idx    = best_idx;
    if (take) begin
      nxt_metric = metric_in;
      nxt_idx    = cnt;
    end
  end

endmodule

// File: rtl/soml_min_sel.sv
// Collects NCAND accumulated metrics per decode and presents the
// minimum and its arrival index on a valid/ready result port.
module soml_min_sel
  import soml_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int NCAND = NCAND_DEF,
  parameter int IW    = $clog2(NCAND)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] metric_in,
  input  logic          metric_vld,
  output logic          busy,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] best_metric,
  output logic [IW-1:0] best_idx,
  output logic          overrun
);

  localparam logic [IW:0] LAST = (IW+1)'(NCAND - 1);
  localparam logic [IW:0] ONE  = (IW+1)'(1);

  state_t        state;
  state_t        state_n;
  logic [IW:0]   cnt;
  logic [IW:0]   cnt_n;
  logic [DW-1:0] best_n;
  logic [IW-1:0] idx_n;
  logic          valid_n;
  logic          busy_n;
  logic          ovr_n;
  logic [DW-1:0] cmp_metric;
  logic [IW-1:0] cmp_idx;

  soml_min_cmp #(
    .DW (DW),
    .IW (IW)
  ) u_cmp (
    .first       (cnt == '0),
    .metric_in   (metric_in),
    .best_metric (best_metric),
    .cnt         (cnt[IW-1:0]),
    .best_idx    (best_idx),
    .nxt_metric  (cmp_metric),
    .nxt_idx     (cmp_idx)
  );

  // A metric is only consumed in SEARCH without a colliding start.
  assign ovr_n = metric_vld && !((state == SEARCH) && !start);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    best_n  = best_metric;
    idx_n   = best_idx;
    valid_n = res_valid;
    busy_n  = busy;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SEARCH;
          cnt_n   = '0;
          busy_n  = 1'b1;
        end
      end
      SEARCH: begin
        if (start) begin
          cnt_n = '0;
        end else if (metric_vld) begin
          best_n = cmp_metric;
          idx_n  = cmp_idx;
          if (cnt == LAST) begin
            state_n = HOLD;
            valid_n = 1'b1;
            busy_n  = 1'b0;
          end else begin
            cnt_n = cnt + ONE;
          end
        end
      end
      HOLD: begin
        if (res_ready) begin
          valid_n = 1'b0;
          if (start) begin
            state_n = SEARCH;
            cnt_n   = '0;
            busy_n  = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      best_metric <= '0;
      best_idx    <= '0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      busy        <= busy_n;
      res_valid   <= valid_n;
      best_metric <= best_n;
      best_idx    <= idx_n;
      overrun     <= ovr_n;
    end
  end

endmodule

// File: tb/tb_soml_min_sel.sv
// Randomized and directed bench for soml_min_sel against a
// queue-based model of one decode's candidate list.
module tb_soml_min_sel;

  localparam int DW    = 16;
  localparam int NCAND = 8;
  localparam int IW    = $clog2(NCAND);

  localparam int M_IDLE   = 0;
  localparam int M_SEARCH = 1;
  localparam int M_HOLD   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] metric_in = '0;
  logic          metric_vld = 1'b0;
  logic          busy;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] best_metric;
  logic [IW-1:0] best_idx;
  logic          overrun;

  int n_cmp = 0;
  int n_bad = 0;

  int          mode = M_IDLE;
  int          q[$];
  int          exp_best = 0;
  int          exp_idx  = 0;
  int          exp_ovr  = 0;

  soml_min_sel #(
    .DW    (DW),
    .NCAND (NCAND)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .metric_in   (metric_in),
    .metric_vld  (metric_vld),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .best_metric (best_metric),
    .best_idx    (best_idx),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Minimum of the whole candidate list, then its first occurrence.
  task automatic model_result();
    int mn;
    mn = q[0];
    foreach (q[i]) if (q[i] < mn) mn = q[i];
    exp_best = mn;
    for (int i = NCAND - 1; i >= 0; i--) if (q[i] == mn) exp_idx = i;
  endtask

  task automatic model_edge(input bit s, input bit v, input int m,
                            input bit r);
    exp_ovr = (v && !(mode == M_SEARCH && !s)) ? 1 : 0;
    case (mode)
      M_IDLE: if (s) begin mode = M_SEARCH; q.delete(); end
      M_SEARCH: begin
        if (s) q.delete();
        else if (v) begin
          q.push_back(m);
          if (q.size() == NCAND) begin
            model_result();
            mode = M_HOLD;
          end
        end
      end
      default: if (r) begin
        if (s) begin mode = M_SEARCH; q.delete(); end
        else mode = M_IDLE;
      end
    endcase
  endtask

  task automatic check_all();
    chk("busy", int'(busy), (mode == M_SEARCH) ? 1 : 0);
    chk("res_valid", int'(res_valid), (mode == M_HOLD) ? 1 : 0);
    chk("overrun", int'(overrun), exp_ovr);
    if (mode != M_SEARCH) begin
      chk("best_metric", int'(best_metric), exp_best);
      chk("best_idx", int'(best_idx), exp_idx);
    end
  endtask

  task automatic step(input bit s, input bit v, input int m, input bit r);
    start      = s;
    metric_vld = v;
    metric_in  = DW'(m);
    res_ready  = r;
    @(posedge clk);
    model_edge(s, v, m, r);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic feed(input int vals[NCAND], input int gap);
    for (int i = 0; i < NCAND; i++) begin
      step(1'b0, 1'b1, vals[i], 1'b0);
      if (i != NCAND - 1) idle(gap);
    end
  endtask

  task automatic accept();
    step(1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    mode     = M_IDLE;
    q.delete();
    exp_best = 0;
    exp_idx  = 0;
    exp_ovr  = 0;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int v1[NCAND] = '{40, 25, 31, 25, 90, 12, 70, 12};
  int v2[NCAND] = '{65535, 65535, 65535, 65535,
                    65535, 65535, 65535, 65535};
  int v3[NCAND] = '{9, 8, 7, 6, 5, 4, 3, 2};
  int v4[NCAND] = '{300, 200, 100, 100, 400, 50, 60, 70};

  initial begin
    rst = 1'b0;
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    step(1'b1, 1'b0, 0, 1'b0);
    feed(v1, 6);
    chk("t1_valid", int'(res_valid), 1);
    chk("t1_best", int'(best_metric), 12);
    chk("t1_idx", int'(best_idx), 5);
    accept();
    idle(2);

    step(1'b1, 1'b0, 0, 1'b0);
    feed(v2, 0);
    chk("t2_best", int'(best_metric), 65535);
    chk("t2_idx", int'(best_idx), 0);
    accept();

    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 5, 1'b0);
    step(1'b0, 1'b1, 4, 1'b0);
    step(1'b0, 1'b1, 3, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    feed(v3, 1);
    chk("t3_best", int'(best_metric), 2);
    chk("t3_idx", int'(best_idx), 7);

    for (int i = 0; i < 10; i++)
      step(1'b0, (i == 2 || i == 6), 7, 1'b0);
    step(1'b1, 1'b0, 0, 1'b1);
    chk("t4_busy", int'(busy), 1);
    chk("t4_valid", int'(res_valid), 0);
    feed(v4, 0);
    chk("t4_best", int'(best_metric), 50);
    accept();

    step(1'b0, 1'b1, 3, 1'b0);
    chk("t5_ovr_idle", int'(overrun), 1);
    step(1'b0, 1'b0, 0, 1'b0);
    chk("t5_ovr_clear", int'(overrun), 0);
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 20, 1'b0);
    step(1'b1, 1'b1, 1, 1'b0);
    chk("t5_ovr_coll", int'(overrun), 1);
    feed(v1, 0);
    chk("t5_best", int'(best_metric), 12);
    accept();

    step(1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 10 - i, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 0, 1'b0);
    feed(v4, 2);
    chk("t6_best", int'(best_metric), 50);
    chk("t6_idx", int'(best_idx), 5);
    accept();

    for (int c = 0; c < 3000; c++) begin
      bit s, v, r;
      int m;
      s = (mode == M_SEARCH) ? ($urandom_range(0, 49) == 0)
                             : ($urandom_range(0, 5) == 0);
      v = ($urandom_range(0, 9) < 4);
      r = $urandom_range(0, 1) == 1;
      m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7))
                                      : int'($urandom_range(0, 65535));
      step(s, v, m, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/soml_min_sel.md
Name: soml_min_sel

Overview:
- Downstream stage of the SOML decoder's per-candidate metric accumulator.
- Each accumulation completes with a one-cycle strobe and a 16-bit summed metric. This block collects NCAND such metrics per decode.
- It tracks the minimum metric and its candidate index, then presents the winner on a valid/ready result interface to the symbol-selection logic.

Parameters:
DW, 16, metric width in bits (matches accumulator output width)
NCAND, 8, candidates per decode; legal range 2..256
IW, $clog2(NCAND), width of candidate index

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
start  input  1  one-cycle pulse; begins a new search (same pulse that starts the first accumulation)
metric_in  input  DW  accumulated metric, unsigned; sampled only when metric_vld=1
metric_vld  input  1  one-cycle strobe from accumulator finish
busy  output  1  high in SEARCH
res_valid  output  1  result available; held until accepted
res_ready  input  1  consumer accepts result when res_valid & res_ready
best_metric  output  DW  minimum metric of the completed search
best_idx  output  IW  arrival index (0-based) of the minimum
overrun  output  1  one-cycle pulse: metric_vld dropped (arrived outside SEARCH, or collided with start)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; cnt=0.
  - busy=0, res_valid=0, best_metric=0, best_idx=0, overrun=0.
- States: IDLE, SEARCH, HOLD. All outputs are registered.
- IDLE:
  - start -> SEARCH, cnt<=0.
  - metric_vld without start -> overrun pulse next cycle; metric discarded.
- SEARCH, on metric_vld=1 (and start=0):
  - If cnt==0, or metric_in < best_metric (unsigned, strict): best_metric<=metric_in, best_idx<=cnt.
  - Ties keep the earlier index.
  - If cnt==NCAND-1: go to HOLD, res_valid<=1, busy<=0. Final compare includes this last metric.
  - Otherwise cnt<=cnt+1.
- SEARCH, on start=1:
  - Restart: cnt<=0; partial best discarded (overwritten on next first metric); stay in SEARCH.
  - If metric_vld is asserted in the same cycle, start wins, the metric is dropped, and overrun pulses.
- Result latency: res_valid rises on the clock edge after the final metric_vld (1 cycle).
- HOLD:
  - res_valid=1; best_metric and best_idx stable.
  - res_valid & res_ready -> IDLE, res_valid<=0.
  - If start is also high in that cycle: -> SEARCH directly, cnt<=0 (back-to-back decodes).
  - start without res_ready: ignored. Upstream must not start before acceptance.
  - metric_vld: dropped, overrun pulses.
- res_ready is ignored outside HOLD.
- Outputs best_metric and best_idx keep the last result in IDLE. They may change during SEARCH and are valid only while res_valid=1.
- No back-pressure to the accumulator: metric_vld is accepted every cycle if required (no minimum spacing).
- cnt width: IW+1 bits; never wraps within a search.

Decomposition:
- Shared package soml_pkg:
  - state enum (IDLE/SEARCH/HOLD)
  - default DW=16 and NCAND constants, reused by the accumulator and the selector.
- One natural sub-module: soml_min_cmp, combinational. Inputs: first flag, metric_in, best_metric, cnt, best_idx. Outputs: next best_metric, next best_idx. It is reusable for a later tree-based parallel min search.

Test Plan:
- Reset, then start, then metrics 40,25,31,25,90,12,70,12 (NCAND=8, spaced 7 cycles) -> res_valid=1 one cycle after 8th strobe, best_metric=12, best_idx=5 (tie at 7 keeps 5).
- All eight metrics equal to 0xFFFF -> best_metric=0xFFFF, best_idx=0. Also first-candidate load with the strict-less compare at max value.
- start, 3 metrics (5,4,3), start again, then 8 metrics 9..2 descending -> best_metric=2, best_idx=7; earlier partial values never appear.
- Complete search, hold res_ready=0 for 10 cycles while pulsing metric_vld twice -> outputs stable, overrun pulses twice. Then res_ready=1 together with start -> res_valid falls and busy rises on the next edge.
- metric_vld in IDLE, and metric_vld coincident with start in SEARCH -> overrun=1 for exactly one cycle each, cnt unaffected.
- Deassert rst mid-SEARCH after 4 metrics -> all outputs 0 asynchronously. After release, a new full search returns the correct minimum.
